// File: rtl/stream_tx_scheduler.sv
// rtl/stream_tx_scheduler.sv - byte-transmit scheduler for the sensor and AT FIFOs
// One byte per grant: READ strobe, UART start/handshake, then a programmable rest gap.
module stream_tx_scheduler #(
  parameter int GAP_W = 10
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             bt_state,
  input  logic             want_at,
  input  logic [7:0]       selected_streams,
  input  logic [8:0]       fifo_empty,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             tx_done,
  output logic [8:0]       rd_en,
  output logic [3:0]       mux_select,
  output logic             start_tx,
  output logic             busy,
  output logic             at_done,
  output logic [2:0]       rr_ptr
);

  typedef enum logic [1:0] {IDLE, READ, SEND, GAP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [2:0]       rr_q, rr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       eligible;
  logic [GAP_W-1:0] gap_last;
  logic             gap_exit;
  logic             rr_hit;
  logic [2:0]       rr_pick;

  assign eligible = selected_streams & ~fifo_empty[7:0];
  assign gap_last = (gap_cycles == '0) ? '0 : gap_cycles - GAP_W'(1);
  // Exit on ">=" so a gap_cycles decrease mid-gap can never strand the counter.
  assign gap_exit = (state_q == GAP) && (gap_q >= gap_last);

  // Scan downward so the smallest offset from rr_q wins.
  always_comb begin
    rr_hit  = 1'b0;
    rr_pick = rr_q;
    for (int k = 7; k >= 0; k--) begin
      if (eligible[rr_q + 3'(k)]) begin
        rr_hit  = 1'b1;
        rr_pick = rr_q + 3'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    gap_d    = gap_q;
    rd_en    = '0;
    start_tx = 1'b0;
    at_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (want_at && !bt_state && !fifo_empty[8]) begin
          sel_d   = 4'd8;
          state_d = READ;
        end else if (bt_state && rr_hit) begin
          sel_d   = {1'b0, rr_pick};
          state_d = READ;
        end
      end
      READ: begin
        rd_en   = 9'd1 << sel_q;
        state_d = SEND;
      end
      SEND: begin
        start_tx = 1'b1;
        if (tx_done) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_exit) begin
          state_d = IDLE;
          if (!sel_q[3]) begin
            rr_d = sel_q[2:0] + 3'd1;
          end
          at_done = sel_q[3] && fifo_empty[8];
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
    end
  end

  assign mux_select = sel_q;
  assign busy       = (state_q != IDLE);
  assign rr_ptr     = rr_q;

endmodule

// File: tb/tb_stream_tx_scheduler.sv
// tb/tb_stream_tx_scheduler.sv - directed bench with a transaction-level scheduler model
`timescale 1ns/1ps
module tb_stream_tx_scheduler;

  localparam int GAP_W = 10;
  localparam int P_IDLE = 0, P_READ = 1, P_SEND = 2, P_GAP = 3;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             bt_state = 1'b0;
  logic             want_at = 1'b0;
  logic [7:0]       selected_streams = 8'h00;
  logic [8:0]       fifo_empty;
  logic [GAP_W-1:0] gap_cycles = '0;
  logic             tx_done = 1'b0;
  logic [8:0]       rd_en;
  logic [3:0]       mux_select;
  logic             start_tx;
  logic             busy;
  logic             at_done;
  logic [2:0]       rr_ptr;

  stream_tx_scheduler #(.GAP_W(GAP_W)) dut (
    .clock(clock), .resetn(resetn), .bt_state(bt_state), .want_at(want_at),
    .selected_streams(selected_streams), .fifo_empty(fifo_empty),
    .gap_cycles(gap_cycles), .tx_done(tx_done), .rd_en(rd_en),
    .mux_select(mux_select), .start_tx(start_tx), .busy(busy),
    .at_done(at_done), .rr_ptr(rr_ptr)
  );

  always #5 clock = ~clock;

  // FIFO occupancy = bytes loaded by the stimulus minus bytes the DUT strobed out.
  int load  [9] = '{default: 0};
  int taken [9] = '{default: 0};
  always_comb begin
    for (int i = 0; i < 9; i++) fifo_empty[i] = (load[i] == taken[i]);
  end

  int tests_m = 0, fails_m = 0, tests_t = 0, fails_t = 0;

  function automatic void chk_m(input bit ok, input string nm, input int act, input int req);
    tests_m++;
    if (!ok) begin
      fails_m++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void chk_t(input bit ok, input string nm, input int act, input int req);
    tests_t++;
    if (!ok) begin
      fails_t++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endfunction

  // UART stand-in: completes after tx_lat cycles of start_tx; tx_force injects stray pulses.
  int   tx_lat = 5;
  logic tx_force = 1'b0;
  int   scnt = 0;
  always @(negedge clock) begin
    if (!resetn) begin
      scnt = 0;
      tx_done = 1'b0;
    end else begin
      if (start_tx) scnt = scnt + 1;
      else scnt = 0;
      tx_done = tx_force || (start_tx && scnt == tx_lat);
    end
  end

  function automatic int pick(input logic bt, input logic want, input logic [7:0] sel,
                              input logic [8:0] emp, input int rr);
    if (want && !bt && !emp[8]) return 8;
    if (bt) begin
      for (int k = 0; k < 8; k++) begin
        int i;
        i = (rr + k) % 8;
        if (sel[i] && !emp[i]) return i;
      end
    end
    return -1;
  endfunction

  int         ph = P_IDLE, prev_idle = 0, cur = 0, scyc = 0, gcyc = 0;
  int         ad_cnt = 0, ad_last = 0, m_rr = 0, last_gap = 0;
  int         ad_total = 0, rd8_total = 0, expg = 0, gexp = 0, ad_exp = 0;
  logic       s_bt, s_want;
  logic [7:0] s_sel;
  logic [8:0] s_emp;
  int         s_rr;
  int         grants[$];
  logic [8:0] rd_log[$];
  int         rr_log[$];

  always @(negedge clock) begin
    if (!resetn) begin
      chk_m({rd_en, mux_select, start_tx, busy, at_done, rr_ptr} == '0, "reset_outputs",
            int'({rd_en, mux_select, start_tx, busy, at_done, rr_ptr}), 0);
      ph = P_IDLE;
      prev_idle = 0;
      m_rr = 0;
    end else begin
      chk_m($onehot0(rd_en) && !(start_tx && rd_en != 0), "rd_en_onehot_vs_start",
            int'({start_tx, rd_en}), 0);
      case (ph)
        P_READ: begin
          chk_m(start_tx && rd_en == 0 && busy, "read_to_send", int'({busy, start_tx, rd_en}), 1536);
          chk_m(mux_select == cur, "mux_hold", mux_select, cur);
          ph = P_SEND;
          scyc = 1;
        end
        P_SEND: begin
          chk_m(mux_select == cur, "mux_hold", mux_select, cur);
          if (start_tx) scyc++;
          else begin
            chk_m(scyc == tx_lat, "send_len", scyc, tx_lat);
            chk_m(busy && rd_en == 0, "gap_entry", int'({busy, rd_en}), 512);
            ph = P_GAP;
            gcyc = 1;
            ad_cnt = at_done;
            ad_last = at_done;
          end
        end
        P_GAP: begin
          if (busy) begin
            chk_m(!start_tx && rd_en == 0, "gap_quiet", int'({start_tx, rd_en}), 0);
            chk_m(mux_select == cur, "mux_hold", mux_select, cur);
            gcyc++;
            ad_cnt += at_done;
            ad_last = at_done;
          end else begin
            gexp = (gap_cycles == 0) ? 1 : int'(gap_cycles);
            chk_m(gcyc == gexp, "gap_len", gcyc, gexp);
            last_gap = gcyc;
            ad_exp = (cur == 8 && load[8] == taken[8]) ? 1 : 0;
            chk_m(ad_cnt == ad_exp && ad_last == ad_exp, "at_done_pulse", ad_cnt, ad_exp);
            ad_total += ad_cnt;
            if (cur < 8) m_rr = (cur + 1) % 8;
            rr_log.push_back(int'(rr_ptr));
            ph = P_IDLE;
            prev_idle = 0;
          end
        end
        default: ;
      endcase
      if (ph == P_IDLE) begin
        if (prev_idle != 0) begin
          expg = pick(s_bt, s_want, s_sel, s_emp, s_rr);
          if (expg >= 0) begin
            chk_m(busy && rd_en == 9'(1 << expg) && mux_select == expg, "grant",
                  int'(rd_en), 1 << expg);
            if (rd_en != 0) begin
              cur = expg;
              grants.push_back(expg);
              rd_log.push_back(rd_en);
              if (rd_en[8]) rd8_total++;
              for (int i = 0; i < 9; i++) if (rd_en[i]) taken[i]++;
              ph = P_READ;
            end
          end else begin
            chk_m(!busy && rd_en == 0, "no_grant", int'({busy, rd_en}), 0);
          end
        end
        if (ph == P_IDLE) begin
          chk_m(rr_ptr == m_rr, "rr_ptr", rr_ptr, m_rr);
          chk_m(!at_done, "at_done_idle", at_done, 0);
          s_bt = bt_state;
          s_want = want_at;
          s_sel = selected_streams;
          s_emp = fifo_empty;
          s_rr = m_rr;
          prev_idle = 1;
        end
      end
    end
  end

  function automatic int gq(input int idx);
    return (grants.size() > idx) ? grants[idx] : -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_quiet(input int maxc, input string nm);
    int q = 0;
    int n = 0;
    while (q < 4 && n < maxc) begin
      @(negedge clock);
      n++;
      if (!busy) q++;
      else q = 0;
    end
    chk_t(q >= 4, nm, n, maxc);
    step();
  endtask

  task automatic wait_start(input int maxc, input string nm);
    int n = 0;
    while (!start_tx && n < maxc) begin
      @(negedge clock);
      n++;
    end
    chk_t(start_tx, nm, n, maxc);
  endtask

  int g0, r0, rr0, a0, t1, d0, t2;
  int exp1[4] = '{1, 3, 1, 3};
  int exprr[4] = '{2, 4, 2, 4};
  int exp5[3] = '{2, 0, 2};

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk_t({rd_en, mux_select, start_tx, busy, at_done, rr_ptr} == '0, "reset_state",
          int'({rd_en, mux_select, start_tx, busy, at_done, rr_ptr}), 0);
    step();
    resetn = 1'b1;
    step();

    // Round-robin between streams 1 and 3
    g0 = grants.size(); r0 = rd_log.size(); rr0 = rr_log.size();
    tx_lat = 20; gap_cycles = 10'd12; selected_streams = 8'hAA;
    load[1] += 2; load[3] += 2; bt_state = 1'b1;
    wait_quiet(600, "t1_timeout");
    chk_t(grants.size() - g0 == 4, "t1_count", grants.size() - g0, 4);
    for (int k = 0; k < 4; k++) begin
      chk_t(gq(g0 + k) == exp1[k], "t1_grant", gq(g0 + k), exp1[k]);
      chk_t(rr_log.size() > rr0 + k && rr_log[rr0 + k] == exprr[k], "t1_rr_ptr",
            (rr_log.size() > rr0 + k) ? rr_log[rr0 + k] : -1, exprr[k]);
    end
    chk_t(rd_log.size() > r0 + 1 && rd_log[r0] == 9'h002 && rd_log[r0 + 1] == 9'h008,
          "t1_rd_en", (rd_log.size() > r0) ? int'(rd_log[r0]) : -1, 2);
    chk_t(last_gap == 12, "t1_gap", last_gap, 12);

    // AT mode: three bytes, one at_done
    g0 = grants.size(); a0 = ad_total; t1 = taken[1];
    tx_lat = 5; gap_cycles = 10'd3; bt_state = 1'b0; want_at = 1'b1;
    load[8] += 3; load[1] += 1;
    wait_quiet(300, "t2_timeout");
    chk_t(grants.size() - g0 == 3, "t2_count", grants.size() - g0, 3);
    for (int k = 0; k < 3; k++) chk_t(gq(g0 + k) == 8, "t2_grant", gq(g0 + k), 8);
    chk_t(ad_total - a0 == 1, "t2_at_done_once", ad_total - a0, 1);
    chk_t(taken[1] == t1, "t2_sensor_untouched", taken[1], t1);
    chk_t(mux_select == 4'd8, "t2_mux_holds", mux_select, 8);

    // Link up wins over AT request
    g0 = grants.size(); d0 = rd8_total;
    bt_state = 1'b1; load[8] += 1; load[0] += 1; selected_streams = 8'h01;
    wait_quiet(200, "t3_timeout");
    chk_t(grants.size() - g0 == 1 && gq(g0) == 0, "t3_stream0", gq(g0), 0);
    chk_t(rd8_total == d0, "t3_no_at_read", rd8_total, d0);
    chk_t(rr_ptr == 3'd1, "t3_rr_ptr", rr_ptr, 1);

    // Link drops mid-SEND: byte completes, no further grant
    g0 = grants.size(); t2 = taken[2];
    want_at = 1'b0; selected_streams = 8'h04; load[2] += 3;
    wait_start(50, "t4_start_timeout");
    step();
    bt_state = 1'b0;
    wait_quiet(200, "t4_timeout");
    chk_t(grants.size() - g0 == 1 && gq(g0) == 2, "t4_one_byte", grants.size() - g0, 1);
    chk_t(taken[2] - t2 == 1, "t4_fifo_reads", taken[2] - t2, 1);

    // Reset mid-SEND, arbitration restarts at stream 0
    g0 = grants.size();
    bt_state = 1'b1;
    wait_start(50, "t5_start_timeout");
    step();
    resetn = 1'b0;
    #1;
    chk_t({rd_en, mux_select, start_tx, busy, at_done, rr_ptr} == '0, "t5_async_reset",
          int'({rd_en, mux_select, start_tx, busy, at_done, rr_ptr}), 0);
    selected_streams = 8'h05; load[0] += 1;
    repeat (3) step();
    resetn = 1'b1;
    wait_quiet(300, "t5_timeout");
    chk_t(grants.size() - g0 == 3, "t5_count", grants.size() - g0, 3);
    for (int k = 0; k < 3; k++) chk_t(gq(g0 + k) == exp5[k], "t5_grant", gq(g0 + k), exp5[k]);

    // Zero gap means one cycle; stray tx_done in IDLE does nothing
    gap_cycles = '0; selected_streams = 8'h01; load[0] += 1;
    wait_quiet(200, "t6_timeout");
    chk_t(last_gap == 1, "t6_gap_zero", last_gap, 1);
    g0 = grants.size();
    tx_force = 1'b1;
    step();
    tx_force = 1'b0;
    repeat (4) step();
    chk_t(!busy && grants.size() == g0, "t6_stray_tx_done", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests_m + tests_t, fails_m + fails_t);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
